// File: rtl/tlp_unpacker.sv
// rtl/tlp_unpacker.sv - consumer end of the ADC packer path: pops TLP headers/data and unpacks 12-bit samples
// Validates header reserved bits and buffer/TLP sequence before streaming samples.
module tlp_unpacker #(
  parameter int WORDS_PER_TLP = 15,
  parameter int DATA_W        = 64,
  parameter int HDR_W         = 40
) (
  input  logic              InputClock,
  input  logic              rst_n,
  input  logic              ADC_type,
  input  logic [15:0]       BufferLengthTLPs,
  input  logic [HDR_W-1:0]  HeaderFifoData,
  input  logic              HeaderFifoEmpty,
  output logic              HeaderRead,
  input  logic [DATA_W-1:0] DataFifoData,
  input  logic              DataFifoEmpty,
  output logic              DataRead,
  output logic [11:0]       SampleData,
  output logic              SampleValid,
  input  logic              SampleReady,
  output logic              SampleFirst,
  output logic [15:0]       HeaderBuffer,
  output logic [15:0]       HeaderTLP,
  output logic [2:0]        HeaderFlags,
  output logic              TLPDone,
  output logic              SeqError,
  output logic              ReservedError,
  output logic [15:0]       ErrorCount
);

  localparam int CNT_W = $clog2(WORDS_PER_TLP + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} stateT;

  stateT             state, nextState;
  logic [DATA_W-1:0] shiftReg;
  logic [2:0]        slot;
  logic [CNT_W-1:0]  wordCount;
  logic              mode;
  logic              synced;

  logic              hdrPop, dataPop, sampleAccept, lastSlot, lastWord, tlpEnd;
  logic [15:0]       hdrBuf, hdrTlp, expBuf, expTlp;
  logic [2:0]        hdrFlags;
  logic [4:0]        hdrRsv;
  logic              seqBad, rsvBad, wrapTlp;
  logic [16:0]       errSum;

  assign hdrBuf   = HeaderFifoData[39:24];
  assign hdrTlp   = HeaderFifoData[23:8];
  assign hdrFlags = HeaderFifoData[7:5];
  assign hdrRsv   = HeaderFifoData[4:0];

  // The latched header fields double as the reference for the next sequence check.
  assign wrapTlp = (HeaderTLP >= BufferLengthTLPs);
  assign expTlp  = wrapTlp ? 16'd0 : HeaderTLP + 16'd1;
  assign expBuf  = wrapTlp ? HeaderBuffer + 16'd1 : HeaderBuffer;
  assign seqBad  = synced && ((hdrTlp != expTlp) || (hdrBuf != expBuf));
  assign rsvBad  = (hdrRsv != 5'b11111);
  assign errSum  = {1'b0, ErrorCount} + {16'd0, seqBad} + {16'd0, rsvBad};

  assign lastSlot = mode ? (slot == 3'd4) : (slot == 3'd7);
  assign lastWord = (wordCount == CNT_W'(WORDS_PER_TLP - 1));

  always_ff @(posedge InputClock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState    = state;
    hdrPop       = 1'b0;
    dataPop      = 1'b0;
    sampleAccept = 1'b0;
    tlpEnd       = 1'b0;
    case (state)
      IDLE: begin
        if (!HeaderFifoEmpty) begin
          hdrPop    = 1'b1;
          nextState = LOAD;
        end
      end
      LOAD: begin
        if (!DataFifoEmpty) begin
          dataPop   = 1'b1;
          nextState = EMIT;
        end
      end
      EMIT: begin
        if (SampleReady) begin
          sampleAccept = 1'b1;
          if (lastSlot) begin
            if (lastWord) begin
              tlpEnd    = 1'b1;
              nextState = IDLE;
            end else begin
              nextState = LOAD;
            end
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Pops are gated by reset so nothing leaves the FIFOs while rst_n is low.
  assign HeaderRead  = hdrPop & rst_n;
  assign DataRead    = dataPop & rst_n;
  assign SampleValid = (state == EMIT);
  assign SampleData  = (state != EMIT) ? 12'd0 :
                       mode ? shiftReg[DATA_W-1 -: 12] : {4'b0000, shiftReg[DATA_W-1 -: 8]};
  assign SampleFirst = (state == EMIT) && (slot == 3'd0) && (wordCount == '0);

  always_ff @(posedge InputClock or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg      <= '0;
      slot          <= '0;
      wordCount     <= '0;
      mode          <= 1'b0;
      synced        <= 1'b0;
      HeaderBuffer  <= '0;
      HeaderTLP     <= '0;
      HeaderFlags   <= '0;
      TLPDone       <= 1'b0;
      SeqError      <= 1'b0;
      ReservedError <= 1'b0;
      ErrorCount    <= '0;
    end else begin
      TLPDone       <= tlpEnd;
      SeqError      <= 1'b0;
      ReservedError <= 1'b0;
      if (hdrPop) begin
        mode          <= ADC_type;
        synced        <= 1'b1;
        wordCount     <= '0;
        HeaderBuffer  <= hdrBuf;
        HeaderTLP     <= hdrTlp;
        HeaderFlags   <= hdrFlags;
        SeqError      <= seqBad;
        ReservedError <= rsvBad;
        ErrorCount    <= errSum[16] ? 16'hFFFF : errSum[15:0];
      end
      if (dataPop) begin
        shiftReg <= DataFifoData;
        slot     <= '0;
      end
      // Samples leave MSB-first; the shift register keeps the head sample stable during stalls.
      if (sampleAccept) begin
        shiftReg <= mode ? (shiftReg << 12) : (shiftReg << 8);
        slot     <= slot + 3'd1;
        if (lastSlot) begin
          wordCount <= wordCount + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tlp_unpacker.sv
// tb/tb_tlp_unpacker.sv - directed self-checking bench for tlp_unpacker
// FWFT FIFO models feed the DUT; a negedge monitor logs accepted samples and pulses.
module tb_tlp_unpacker;

  logic        InputClock = 1'b0;
  logic        rst_n;
  logic        ADC_type;
  logic [15:0] BufferLengthTLPs;
  logic [39:0] HeaderFifoData;
  logic        HeaderFifoEmpty;
  logic        HeaderRead;
  logic [63:0] DataFifoData;
  logic        DataFifoEmpty;
  logic        DataRead;
  logic [11:0] SampleData;
  logic        SampleValid;
  logic        SampleReady;
  logic        SampleFirst;
  logic [15:0] HeaderBuffer;
  logic [15:0] HeaderTLP;
  logic [2:0]  HeaderFlags;
  logic        TLPDone;
  logic        SeqError;
  logic        ReservedError;
  logic [15:0] ErrorCount;

  logic        dataHold;
  logic        flush;

  int tests = 0;
  int fails = 0;

  always #5 InputClock = ~InputClock;

  tlp_unpacker dut (
    .InputClock(InputClock), .rst_n(rst_n), .ADC_type(ADC_type),
    .BufferLengthTLPs(BufferLengthTLPs),
    .HeaderFifoData(HeaderFifoData), .HeaderFifoEmpty(HeaderFifoEmpty), .HeaderRead(HeaderRead),
    .DataFifoData(DataFifoData), .DataFifoEmpty(DataFifoEmpty), .DataRead(DataRead),
    .SampleData(SampleData), .SampleValid(SampleValid), .SampleReady(SampleReady),
    .SampleFirst(SampleFirst), .HeaderBuffer(HeaderBuffer), .HeaderTLP(HeaderTLP),
    .HeaderFlags(HeaderFlags), .TLPDone(TLPDone), .SeqError(SeqError),
    .ReservedError(ReservedError), .ErrorCount(ErrorCount)
  );

  logic [39:0] hdrMem [0:15];
  logic [63:0] dataMem [0:255];
  int hdrWr = 0, hdrRd = 0, dataWr = 0, dataRd = 0;

  assign HeaderFifoData  = hdrMem[hdrRd[3:0]];
  assign HeaderFifoEmpty = (hdrRd == hdrWr);
  assign DataFifoData    = dataMem[dataRd[7:0]];
  assign DataFifoEmpty   = (dataRd == dataWr) || dataHold;

  always @(posedge InputClock) begin
    if (flush) begin
      hdrRd  <= hdrWr;
      dataRd <= dataWr;
    end else begin
      if (HeaderRead) hdrRd <= hdrRd + 1;
      if (DataRead) dataRd <= dataRd + 1;
    end
  end

  logic [11:0] sampArr [0:2047];
  logic        firstArr [0:2047];
  int nSamp = 0, doneCnt = 0, seqCnt = 0, resCnt = 0, bothCnt = 0, readCnt = 0;

  always @(negedge InputClock) begin
    if (SampleValid && SampleReady && nSamp < 2048) begin
      sampArr[nSamp]  = SampleData;
      firstArr[nSamp] = SampleFirst;
      nSamp++;
    end
    if (TLPDone) doneCnt++;
    if (SeqError) seqCnt++;
    if (ReservedError) resCnt++;
    if (SeqError && ReservedError) bothCnt++;
    if (DataRead) readCnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge InputClock);
      #1;
    end
  endtask

  task automatic push_tlp(input logic [15:0] b, input logic [15:0] t, input logic [2:0] fl,
                          input logic [4:0] rsv, input logic [63:0] w0, input logic [63:0] inc);
    for (int k = 0; k < 15; k++) begin
      dataMem[dataWr[7:0]] = w0 + inc * 64'(k);
      dataWr++;
    end
    hdrMem[hdrWr[3:0]] = {b, t, fl, rsv};
    hdrWr++;
  endtask

  task automatic wait_nsamp(input int target, input int budget, input string name);
    int n = 0;
    while (nSamp < target && n < budget) begin
      step(1);
      n++;
    end
    if (nSamp < target) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got %0d samples, required %0d", name, nSamp, target);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ADC_type = 1'b0;
    BufferLengthTLPs = 16'd2;
    SampleReady = 1'b1;
    dataHold = 1'b0;
    flush = 1'b0;
    hdrMem[hdrWr[3:0]] = 40'hAAAA_5555_FF;
    hdrWr++;
    step(2);
    tests++;
    if (HeaderRead !== 1'b0 || DataRead !== 1'b0) begin
      fails++;
      $display("FAIL reset_pops: HeaderRead=%b DataRead=%b, required 0 0", HeaderRead, DataRead);
    end
    tests++;
    if ({SampleValid, SampleFirst, SampleData} !== 14'd0) begin
      fails++;
      $display("FAIL reset_sample: valid=%b first=%b data=%h, required 0", SampleValid, SampleFirst, SampleData);
    end
    tests++;
    if ({HeaderBuffer, HeaderTLP, HeaderFlags} !== 35'd0) begin
      fails++;
      $display("FAIL reset_header: %h/%h/%b, required 0", HeaderBuffer, HeaderTLP, HeaderFlags);
    end
    tests++;
    if ({TLPDone, SeqError, ReservedError} !== 3'd0 || ErrorCount !== 16'd0) begin
      fails++;
      $display("FAIL reset_status: pulses=%b%b%b count=%0d, required 0", TLPDone, SeqError, ReservedError, ErrorCount);
    end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic8();
    int s0 = nSamp, d0 = doneCnt, q0 = seqCnt, r0 = resCnt;
    int bad = -1, firsts = 0;
    ADC_type = 1'b0;
    push_tlp(16'd0, 16'd0, 3'b101, 5'b11111, 64'h0001020304050607, 64'h0808080808080808);
    wait_nsamp(s0 + 120, 400, "basic8");
    step(3);
    tests++;
    if (nSamp - s0 != 120) begin
      fails++;
      $display("FAIL basic8_count: got %0d, required 120", nSamp - s0);
    end
    for (int i = 0; i < 120; i++) begin
      if (bad < 0 && sampArr[s0 + i] !== 12'(i)) bad = i;
      if (firstArr[s0 + i] === 1'b1) firsts++;
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL basic8_stream: sample %0d = %h, required %h", bad, sampArr[s0 + bad], 12'(bad));
    end
    tests++;
    if (firstArr[s0] !== 1'b1 || firsts != 1) begin
      fails++;
      $display("FAIL basic8_first: first0=%b total=%0d, required 1 1", firstArr[s0], firsts);
    end
    tests++;
    if (HeaderFlags !== 3'b101 || HeaderBuffer !== 16'd0 || HeaderTLP !== 16'd0) begin
      fails++;
      $display("FAIL basic8_header: flags=%b buf=%0d tlp=%0d, required 101 0 0", HeaderFlags, HeaderBuffer, HeaderTLP);
    end
    tests++;
    if (doneCnt - d0 != 1 || seqCnt != q0 || resCnt != r0 || ErrorCount !== 16'd0) begin
      fails++;
      $display("FAIL basic8_status: done=%0d seq=%0d res=%0d cnt=%0d, required 1 0 0 0",
               doneCnt - d0, seqCnt - q0, resCnt - r0, ErrorCount);
    end
  endtask

  task automatic test_unpack12();
    int s0 = nSamp, d0 = doneCnt, q0 = seqCnt;
    int bad = -1;
    logic [11:0] pat [0:4];
    pat[0] = 12'h123; pat[1] = 12'h456; pat[2] = 12'h789; pat[3] = 12'hABC; pat[4] = 12'hDEF;
    ADC_type = 1'b1;
    push_tlp(16'd0, 16'd1, 3'b010, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    wait_nsamp(s0 + 10, 100, "unpack12_start");
    ADC_type = 1'b0;
    wait_nsamp(s0 + 75, 300, "unpack12");
    step(3);
    tests++;
    if (nSamp - s0 != 75) begin
      fails++;
      $display("FAIL unpack12_count: got %0d, required 75", nSamp - s0);
    end
    for (int i = 0; i < 75; i++) begin
      if (bad < 0 && sampArr[s0 + i] !== pat[i % 5]) bad = i;
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL unpack12_stream: sample %0d = %h, required %h", bad, sampArr[s0 + bad], pat[bad % 5]);
    end
    tests++;
    if (doneCnt - d0 != 1 || seqCnt != q0 || HeaderTLP !== 16'd1) begin
      fails++;
      $display("FAIL unpack12_status: done=%0d seq=%0d tlp=%0d, required 1 0 1", doneCnt - d0, seqCnt - q0, HeaderTLP);
    end
  endtask

  task automatic test_seq_wrap();
    int s0, q0;
    apply_reset();
    ADC_type = 1'b1;
    s0 = nSamp;
    q0 = seqCnt;
    push_tlp(16'd5, 16'd0, 3'b000, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    push_tlp(16'd5, 16'd1, 3'b000, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    push_tlp(16'd5, 16'd2, 3'b000, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    push_tlp(16'd6, 16'd0, 3'b000, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    wait_nsamp(s0 + 300, 1000, "seq_wrap_a");
    step(3);
    tests++;
    if (seqCnt != q0 || ErrorCount !== 16'd0) begin
      fails++;
      $display("FAIL seq_wrap_clean: seq=%0d cnt=%0d, required 0 0", seqCnt - q0, ErrorCount);
    end
    push_tlp(16'd6, 16'd2, 3'b000, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    wait_nsamp(s0 + 375, 300, "seq_wrap_b");
    step(3);
    tests++;
    if (seqCnt - q0 != 1 || ErrorCount !== 16'd1) begin
      fails++;
      $display("FAIL seq_wrap_err: seq=%0d cnt=%0d, required 1 1", seqCnt - q0, ErrorCount);
    end
    push_tlp(16'd7, 16'd0, 3'b000, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    wait_nsamp(s0 + 450, 300, "seq_wrap_c");
    step(3);
    tests++;
    if (seqCnt - q0 != 1 || HeaderBuffer !== 16'd7 || HeaderTLP !== 16'd0) begin
      fails++;
      $display("FAIL seq_wrap_resync: seq=%0d buf=%0d tlp=%0d, required 1 7 0", seqCnt - q0, HeaderBuffer, HeaderTLP);
    end
  endtask

  task automatic test_reserved();
    int s0 = nSamp, q0 = seqCnt, r0 = resCnt, b0 = bothCnt;
    push_tlp(16'd7, 16'd1, 3'b000, 5'b11011, 64'h123456789ABCDEF0, 64'd0);
    wait_nsamp(s0 + 75, 300, "reserved_a");
    step(3);
    tests++;
    if (resCnt - r0 != 1 || seqCnt != q0 || ErrorCount !== 16'd2) begin
      fails++;
      $display("FAIL reserved_only: res=%0d seq=%0d cnt=%0d, required 1 0 2", resCnt - r0, seqCnt - q0, ErrorCount);
    end
    push_tlp(16'd9, 16'd9, 3'b000, 5'b11011, 64'h123456789ABCDEF0, 64'd0);
    wait_nsamp(s0 + 150, 300, "reserved_b");
    step(3);
    tests++;
    if (bothCnt - b0 != 1 || ErrorCount !== 16'd4 || HeaderTLP !== 16'd9) begin
      fails++;
      $display("FAIL reserved_both: both=%0d cnt=%0d tlp=%0d, required 1 4 9", bothCnt - b0, ErrorCount, HeaderTLP);
    end
  endtask

  task automatic test_backpressure();
    int s0 = nSamp, d0 = doneCnt, q0 = seqCnt, rd0;
    int bad = -1, stallBad = 0;
    logic [11:0] held;
    ADC_type = 1'b0;
    push_tlp(16'd10, 16'd0, 3'b011, 5'b11111, 64'h0001020304050607, 64'h0808080808080808);
    wait_nsamp(s0 + 3, 100, "stall_start");
    SampleReady = 1'b0;
    dataHold = 1'b1;
    held = SampleData;
    rd0 = readCnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge InputClock);
      if (SampleData !== held || SampleValid !== 1'b1) stallBad++;
    end
    tests++;
    if (held !== 12'h003 || stallBad != 0) begin
      fails++;
      $display("FAIL stall_hold: held=%h unstable=%0d, required 003 0", held, stallBad);
    end
    @(posedge InputClock);
    #1;
    SampleReady = 1'b1;
    step(30);
    tests++;
    if (SampleValid !== 1'b0 || nSamp - s0 != 8 || readCnt != rd0) begin
      fails++;
      $display("FAIL empty_wait: valid=%b samples=%0d reads=%0d, required 0 8 0",
               SampleValid, nSamp - s0, readCnt - rd0);
    end
    dataHold = 1'b0;
    wait_nsamp(s0 + 120, 400, "refill");
    step(3);
    for (int i = 0; i < 120; i++) begin
      if (bad < 0 && sampArr[s0 + i] !== 12'(i)) bad = i;
    end
    tests++;
    if (bad >= 0 || nSamp - s0 != 120) begin
      fails++;
      $display("FAIL refill_stream: first bad %0d count %0d, required -1 120", bad, nSamp - s0);
    end
    tests++;
    if (doneCnt - d0 != 1 || seqCnt != q0) begin
      fails++;
      $display("FAIL refill_status: done=%0d seq=%0d, required 1 0", doneCnt - d0, seqCnt - q0);
    end
  endtask

  task automatic test_reset_mid();
    int s0 = nSamp, s1, d0, q0;
    ADC_type = 1'b1;
    push_tlp(16'd10, 16'd1, 3'b000, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    wait_nsamp(s0 + 40, 200, "reset_mid_start");
    rst_n = 1'b0;
    flush = 1'b1;
    #1;
    tests++;
    if ({SampleValid, SampleFirst, SampleData, HeaderRead, DataRead, TLPDone, SeqError, ReservedError} !== 19'd0 ||
        ErrorCount !== 16'd0 || {HeaderBuffer, HeaderTLP, HeaderFlags} !== 35'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: valid=%b data=%h cnt=%0d buf=%0d, required all 0",
               SampleValid, SampleData, ErrorCount, HeaderBuffer);
    end
    step(1);
    flush = 1'b0;
    rst_n = 1'b1;
    step(1);
    s1 = nSamp;
    d0 = doneCnt;
    q0 = seqCnt;
    push_tlp(16'd50, 16'd7, 3'b100, 5'b11111, 64'h123456789ABCDEF0, 64'd0);
    wait_nsamp(s1 + 75, 300, "reset_mid_after");
    step(3);
    tests++;
    if (seqCnt != q0 || ErrorCount !== 16'd0 || HeaderBuffer !== 16'd50 || HeaderTLP !== 16'd7) begin
      fails++;
      $display("FAIL reset_mid_resync: seq=%0d cnt=%0d buf=%0d tlp=%0d, required 0 0 50 7",
               seqCnt - q0, ErrorCount, HeaderBuffer, HeaderTLP);
    end
    tests++;
    if (nSamp - s1 != 75 || sampArr[s1] !== 12'h123 || firstArr[s1] !== 1'b1 || doneCnt - d0 != 1) begin
      fails++;
      $display("FAIL reset_mid_tlp: samples=%0d s0=%h first=%b done=%0d, required 75 123 1 1",
               nSamp - s1, sampArr[s1], firstArr[s1], doneCnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic8();
    test_unpack12();
    test_seq_wrap();
    test_reserved();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
